// File: rtl/layer_tile_sequencer.sv
// Walks one convolution layer in SYSTOLIC_SIZE-wide output tiles, issuing a start/done handshake per tile.
// Optional LAYER_SEQ_PERF_EN adds perf_cycles / perf_tiles counters.
module layer_tile_sequencer #(
   parameter int SYSTOLIC_SIZE  = 16,
   parameter int DIM_WIDTH      = 10,
   parameter int CNT_WIDTH      = 10,
   parameter int IFM_ADDR_WIDTH = 19,
   parameter int WGT_ADDR_WIDTH = 9,
   parameter int OFM_ADDR_WIDTH = 22
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [DIM_WIDTH-1:0]      cfg_ifm_size,
   input  logic [1:0]                cfg_kernel,
   input  logic [CNT_WIDTH-1:0]      cfg_channels,
   input  logic [CNT_WIDTH-1:0]      cfg_filters,
   input  logic [IFM_ADDR_WIDTH-1:0] cfg_ifm_base,
   input  logic [WGT_ADDR_WIDTH-1:0] cfg_wgt_base,
   input  logic [OFM_ADDR_WIDTH-1:0] cfg_ofm_base,
   input  logic                      abort,
   output logic                      tile_start,
   input  logic                      tile_done,
   output logic [IFM_ADDR_WIDTH-1:0] tile_ifm_addr,
   output logic [WGT_ADDR_WIDTH-1:0] tile_wgt_addr,
   output logic [OFM_ADDR_WIDTH-1:0] tile_ofm_addr,
   output logic [DIM_WIDTH-1:0]      tile_row,
   output logic [DIM_WIDTH-1:0]      tile_col,
   output logic [DIM_WIDTH-1:0]      tile_cols,
   output logic [CNT_WIDTH-1:0]      tile_group,
   output logic                      busy,
   output logic                      layer_done,
   output logic                      cfg_error
`ifdef LAYER_SEQ_PERF_EN
   ,
   output logic [31:0]               perf_cycles,
   output logic [31:0]               perf_tiles
`endif
);

   localparam logic [DIM_WIDTH-1:0]      S_DIM   = DIM_WIDTH'(SYSTOLIC_SIZE);
   localparam logic [CNT_WIDTH-1:0]      S_CNT   = CNT_WIDTH'(SYSTOLIC_SIZE);
   localparam logic [IFM_ADDR_WIDTH-1:0] S_IFM   = IFM_ADDR_WIDTH'(SYSTOLIC_SIZE);
   localparam logic [OFM_ADDR_WIDTH-1:0] S_OFM   = OFM_ADDR_WIDTH'(SYSTOLIC_SIZE);
   localparam logic [DIM_WIDTH-1:0]      ONE_DIM = DIM_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]      ONE_CNT = CNT_WIDTH'(1);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE} state_t;
   state_t state;

   logic [DIM_WIDTH-1:0]      ifm_size_q, out_dim_q, last_row_q, last_col_idx_q, last_cols_q;
   logic [1:0]                kernel_q;
   logic [CNT_WIDTH-1:0]      channels_q, last_group_q;
   logic [IFM_ADDR_WIDTH-1:0] ifm_base_q;
   logic [WGT_ADDR_WIDTH-1:0] wgt_base_q, wgt_stride_q;
   logic [OFM_ADDR_WIDTH-1:0] ofm_base_q, ofm_stride_q;
   logic                      reject_q;

   logic [DIM_WIDTH-1:0]      col_idx;
   logic [IFM_ADDR_WIDTH-1:0] ifm_row_acc;
   logic [OFM_ADDR_WIDTH-1:0] ofm_row_acc, ofm_grp_acc;

   // Derived layer geometry, evaluated from the raw descriptor at accept.
   logic [DIM_WIDTH-1:0] kernel_dim, out_dim_c, last_col_idx_c, last_cols_c;
   logic [CNT_WIDTH-1:0] last_group_c;
   logic                 reject_c;

   assign kernel_dim     = DIM_WIDTH'(cfg_kernel);
   assign out_dim_c      = cfg_ifm_size - kernel_dim + ONE_DIM;
   assign last_col_idx_c = (out_dim_c - ONE_DIM) / S_DIM;
   assign last_cols_c    = ((out_dim_c - ONE_DIM) % S_DIM) + ONE_DIM;
   assign last_group_c   = (cfg_filters - ONE_CNT) / S_CNT;
   assign reject_c       = (cfg_kernel == 2'd0) || (kernel_dim > cfg_ifm_size) ||
                           (cfg_channels == '0) || (cfg_filters == '0);

   // Per-group strides; the only multipliers, used once per layer in CHECK.
   logic [3:0]             kk_c;
   logic [CNT_WIDTH+3:0]   kkc_c;
   logic [2*DIM_WIDTH-1:0] oo_c;

   assign kk_c  = {2'b00, kernel_q} * {2'b00, kernel_q};
   assign kkc_c = {{CNT_WIDTH{1'b0}}, kk_c} * {4'b0000, channels_q};
   assign oo_c  = {{DIM_WIDTH{1'b0}}, out_dim_q} * {{DIM_WIDTH{1'b0}}, out_dim_q};

   logic [IFM_ADDR_WIDTH-1:0] ifm_size_ext;
   logic [OFM_ADDR_WIDTH-1:0] out_dim_ext;
   logic [DIM_WIDTH-1:0]      first_cols;
   logic                      col_last, row_last, group_last;

   assign ifm_size_ext = IFM_ADDR_WIDTH'(ifm_size_q);
   assign out_dim_ext  = OFM_ADDR_WIDTH'(out_dim_q);
   assign first_cols   = (last_col_idx_q == '0) ? last_cols_q : S_DIM;
   assign col_last     = (col_idx == last_col_idx_q);
   assign row_last     = (tile_row == last_row_q);
   assign group_last   = (tile_group == last_group_q);

   assign cfg_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (state == S_IDLE && cfg_valid) begin
         ifm_size_q     <= cfg_ifm_size;
         kernel_q       <= cfg_kernel;
         channels_q     <= cfg_channels;
         ifm_base_q     <= cfg_ifm_base;
         wgt_base_q     <= cfg_wgt_base;
         ofm_base_q     <= cfg_ofm_base;
         out_dim_q      <= out_dim_c;
         last_row_q     <= out_dim_c - ONE_DIM;
         last_col_idx_q <= last_col_idx_c;
         last_cols_q    <= last_cols_c;
         last_group_q   <= last_group_c;
         reject_q       <= reject_c;
      end
      if (state == S_CHECK) begin
         wgt_stride_q <= WGT_ADDR_WIDTH'(kkc_c);
         ofm_stride_q <= OFM_ADDR_WIDTH'(oo_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         tile_start    <= 1'b0;
         layer_done    <= 1'b0;
         cfg_error     <= 1'b0;
         tile_ifm_addr <= '0;
         tile_wgt_addr <= '0;
         tile_ofm_addr <= '0;
         tile_row      <= '0;
         tile_col      <= '0;
         tile_cols     <= '0;
         tile_group    <= '0;
         col_idx       <= '0;
         ifm_row_acc   <= '0;
         ofm_row_acc   <= '0;
         ofm_grp_acc   <= '0;
`ifdef LAYER_SEQ_PERF_EN
         perf_cycles   <= '0;
         perf_tiles    <= '0;
`endif
      end else begin
         tile_start <= 1'b0;
         layer_done <= 1'b0;
         cfg_error  <= 1'b0;
`ifdef LAYER_SEQ_PERF_EN
         if (state == S_IDLE && cfg_valid) begin
            perf_cycles <= '0;
            perf_tiles  <= '0;
         end else if (state != S_IDLE && state != S_DONE && perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
         end
         if ((state == S_CHECK && !abort && !reject_q) ||
             (state == S_ADVANCE && !abort && !(col_last && row_last && group_last))) begin
            perf_tiles <= perf_tiles + 32'd1;
         end
`endif
         if (abort && state != S_IDLE) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cfg_valid) begin
                     state     <= S_CHECK;
                     cfg_error <= reject_c;
                  end
               end
               S_CHECK: begin
                  if (reject_q) begin
                     state <= S_IDLE;
                  end else begin
                     state         <= S_ISSUE;
                     tile_start    <= 1'b1;
                     tile_group    <= '0;
                     tile_row      <= '0;
                     tile_col      <= '0;
                     col_idx       <= '0;
                     tile_cols     <= first_cols;
                     tile_ifm_addr <= ifm_base_q;
                     ifm_row_acc   <= ifm_base_q;
                     tile_wgt_addr <= wgt_base_q;
                     tile_ofm_addr <= ofm_base_q;
                     ofm_row_acc   <= ofm_base_q;
                     ofm_grp_acc   <= ofm_base_q;
                  end
               end
               S_ISSUE: state <= S_WAIT;
               S_WAIT: begin
                  if (tile_done) state <= S_ADVANCE;
               end
               S_ADVANCE: begin
                  if (col_last && row_last && group_last) begin
                     state      <= S_DONE;
                     layer_done <= 1'b1;
                  end else begin
                     state      <= S_ISSUE;
                     tile_start <= 1'b1;
                     if (!col_last) begin
                        col_idx       <= col_idx + ONE_DIM;
                        tile_col      <= tile_col + S_DIM;
                        tile_cols     <= (col_idx + ONE_DIM == last_col_idx_q) ? last_cols_q : S_DIM;
                        tile_ifm_addr <= tile_ifm_addr + S_IFM;
                        tile_ofm_addr <= tile_ofm_addr + S_OFM;
                     end else begin
                        col_idx   <= '0;
                        tile_col  <= '0;
                        tile_cols <= first_cols;
                        if (!row_last) begin
                           tile_row      <= tile_row + ONE_DIM;
                           ifm_row_acc   <= ifm_row_acc + ifm_size_ext;
                           tile_ifm_addr <= ifm_row_acc + ifm_size_ext;
                           ofm_row_acc   <= ofm_row_acc + out_dim_ext;
                           tile_ofm_addr <= ofm_row_acc + out_dim_ext;
                        end else begin
                           // New filter group: rows restart, weights and OFM plane advance.
                           tile_row      <= '0;
                           tile_group    <= tile_group + ONE_CNT;
                           tile_wgt_addr <= tile_wgt_addr + wgt_stride_q;
                           ofm_grp_acc   <= ofm_grp_acc + ofm_stride_q;
                           ofm_row_acc   <= ofm_grp_acc + ofm_stride_q;
                           tile_ofm_addr <= ofm_grp_acc + ofm_stride_q;
                           ifm_row_acc   <= ifm_base_q;
                           tile_ifm_addr <= ifm_base_q;
                        end
                     end
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/layer_tile_sequencer.md
# layer_tile_sequencer

Runtime-configurable tile sequencer that generalises the fixed layer-0 control flow to any convolution layer. It accepts one layer descriptor (IFM size, kernel size, channels, filters, base addresses). It then walks the output in SYSTOLIC_SIZE-wide tiles, issuing one start/done handshake per tile to the PE-array control path together with that tile's IFM, WGT and OFM base addresses. It sits between the host/layer scheduler and the per-tile main controller and address controllers.

## Interface
- SYSTOLIC_SIZE, 16, PE array width; output columns and filters per tile
- DIM_WIDTH, 10, width of IFM/OFM dimension fields
- CNT_WIDTH, 10, width of channel and filter count fields
- IFM_ADDR_WIDTH, 19, IFM address width
- WGT_ADDR_WIDTH, 9, WGT address width
- OFM_ADDR_WIDTH, 22, OFM address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  high only in IDLE
- cfg_ifm_size  in  DIM_WIDTH  square IFM side
- cfg_kernel  in  2  kernel side K (1..3)
- cfg_channels  in  CNT_WIDTH  input channels
- cfg_filters  in  CNT_WIDTH  output filters
- cfg_ifm_base / cfg_wgt_base / cfg_ofm_base  in  IFM/WGT/OFM_ADDR_WIDTH  base addresses
- abort  in  1  synchronous abandon of the current layer
- tile_start  out  1  one-cycle pulse; tile_* fields valid
- tile_done  in  1  one-cycle pulse from the tile controller
- tile_ifm_addr / tile_wgt_addr / tile_ofm_addr  out  per-width  tile base addresses
- tile_row  out  DIM_WIDTH  output row r
- tile_col  out  DIM_WIDTH  first output column of the tile (c·S)
- tile_cols  out  DIM_WIDTH  valid columns in the tile (1..S)
- tile_group  out  CNT_WIDTH  filter group g
- busy  out  1  high outside IDLE
- layer_done  out  1  one-cycle pulse after the last tile_done
- cfg_error  out  1  one-cycle pulse on a rejected descriptor

## Operation
- Derived values: O = ifm_size − K + 1; C = ceil(O/S) column tiles; G = ceil(filters/S) filter groups. All are latched at accept.
- Loop order: group g is outermost, then row r (0..O−1), then column tile c (0..C−1) innermost.
- Address for tile (g, r, c), all modulo 2^width:
  - ifm = ifm_base + r·ifm_size + c·S
  - wgt = wgt_base + g·K·K·channels
  - ofm = ofm_base + g·O·O + r·O + c·S
- Addresses are updated by adding strides to running accumulators. There are no multipliers on the tile path; the K·K·channels and O·O strides are computed once, in CHECK.
- tile_cols = S, except the last column tile, where tile_cols = O − (C−1)·S.
- States:
  - IDLE: cfg_ready=1. Goes to CHECK on cfg_valid.
  - CHECK: goes to IDLE with a cfg_error pulse if K=0, K>ifm_size, channels=0 or filters=0. Otherwise goes to ISSUE.
  - ISSUE: tile_start=1 for one cycle, then goes to WAIT.
  - WAIT: goes to ADVANCE on tile_done.
  - ADVANCE: goes to DONE if this was the last tile (g=G−1, r=O−1, c=C−1); otherwise goes to ISSUE.
  - DONE: layer_done=1 for one cycle, then goes to IDLE.
- tile_done is sampled only in WAIT and ignored in every other state, including the ISSUE cycle itself.
- abort in any non-IDLE state returns to IDLE on the next edge. It produces no layer_done and no further tile_start.
- cfg_* is captured only on accept; changes while busy have no effect.

## Timing
- Reset values: cfg_ready=1; busy, tile_start, layer_done and cfg_error = 0; all tile_* fields = 0.
- Cycle numbering for one layer:
  - Descriptor accepted at edge 0; CHECK in cycle 1.
  - First tile_start in cycle 2, or cfg_error in cycle 1 if rejected.
  - tile_done in cycle t gives ADVANCE in t+1 and the next tile_start in t+2. The per-tile overhead is 2 cycles after done.
  - Last tile_done in cycle t gives layer_done in cycle t+2; cfg_ready returns in cycle t+3.
- tile_* fields change only on entry to ISSUE and are held stable through WAIT.
- Reset asserted mid-layer forces IDLE and the reset values immediately (asynchronously).

## Configuration
- LAYER_SEQ_PERF_EN defined:
  - Adds output perf_cycles[31:0]: cycles from accept to layer_done, saturating at all-ones.
  - Adds output perf_tiles[31:0]: count of tile_start pulses.
  - Both clear on accept and hold their value after DONE or abort.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- Layer-0 descriptor (ifm 416, K=3, ch=3, filters=16, S=16) -> O=414, C=26, exactly 10764 tile_start pulses. Last tile: row 413, col 400, cols 14, ifm_addr=base+172208, ofm_addr=base+171382. One layer_done.
- Descriptor ifm 18, K=3, ch=3, filters=20 -> G=2, 32 tiles. Tile 16 has group 1, wgt_addr=wgt_base+27, ofm_addr=ofm_base+256.
- Descriptor K=3, ifm 2 -> cfg_error in cycle 1, no tile_start, cfg_ready=1 in cycle 2.
- tile_done pulsed in IDLE and in the ISSUE cycle -> ignored; the sequencer waits for a WAIT-state done.
- abort during WAIT of tile 5 -> IDLE next cycle, no layer_done, a new descriptor is accepted.
- rst during WAIT -> all outputs at reset values immediately; the next layer runs from tile 0.
